// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared types and constants for the PWM capture block.
//   pwm_state_e : measurement FSM states (IDLE, HIGH, LOW)
//   PWM_W       : default counter / output width
// -----------------------------------------------------------------------------
package pwm_pkg;

    localparam int unsigned PWM_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // waiting for a first rise; no period in progress
        HIGH = 2'd1,  // high phase of a period being measured
        LOW  = 2'd2   // low phase of a period being measured
    } pwm_state_e;

endpackage

// File: rtl/pwm_in_cond.sv
// -----------------------------------------------------------------------------
// pwm_in_cond
// Input conditioning for the PWM capture block: 2-FF synchronizer, optional
// glitch filter, and one-cycle edge detection on the conditioned level.
//
// Optional feature: define PWM_CAPTURE_FILTER_EN to insert a glitch filter
// that only accepts a new level after it has been stable for FILT_LEN cycles.
//
// Ports:
//   clk_i   in   system clock
//   rst_i   in   asynchronous active-high reset
//   pwm_i   in   raw PWM input, asynchronous to clk_i
//   rise_o  out  conditioned level went 0 -> 1 (valid for one cycle)
//   fall_o  out  conditioned level went 1 -> 0 (valid for one cycle)
// -----------------------------------------------------------------------------
module pwm_in_cond #(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pwm_i,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic s;
    logic s_d_q;

    if (FILT_LEN == 0) begin : g_bad_filt_len
        $error("FILT_LEN must be at least 1");
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pwm_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int unsigned CntW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [CntW-1:0] filt_cnt_q;
    logic [CntW-1:0] filt_cnt_d;
    logic            filt_q;
    logic            filt_d;

    // Count consecutive cycles where the synchronized input disagrees with the
    // accepted level; any agreeing cycle restarts the count.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (sync2_q != filt_q) begin
            if (filt_cnt_q == CntW'(FILT_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            filt_q     <= 1'b0;
            filt_cnt_q <= '0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    assign s = filt_q;
`else
    assign s = sync2_q;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_d_q <= 1'b0;
        end else begin
            s_d_q <= s;
        end
    end

    assign rise_o = s & ~s_d_q;
    assign fall_o = ~s & s_d_q;

endmodule

// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
// Measures each complete period of an asynchronous PWM waveform in clk cycles
// and reports it in generator terms: duty (high cycles) and final_value
// (period - 1). A constant input produces a single timeout report with
// final_value = MAX and stuck = 1.
//
// Optional feature: PWM_CAPTURE_FILTER_EN (see pwm_in_cond) adds a FILT_LEN
// cycle glitch filter in front of the edge detector.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   pwm_in       in   PWM input, asynchronous to clk
//   duty         out  high time of the last measured period (W bits)
//   final_value  out  last measured period - 1 (W bits)
//   valid        out  one-cycle strobe, outputs updated on the same edge
//   stuck        out  last report was a timeout rather than a period
// -----------------------------------------------------------------------------
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned W        = PWM_W,
    parameter int unsigned FILT_LEN = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pwm_in,
    output logic [W-1:0] duty,
    output logic [W-1:0] final_value,
    output logic         valid,
    output logic         stuck
);

    localparam logic [W-1:0] MaxVal = '1;
    localparam logic [W-1:0] Limit  = MaxVal - W'(1);

    logic rise;
    logic fall;

    pwm_in_cond #(
        .FILT_LEN (FILT_LEN)
    ) u_in_cond (
        .clk_i  (clk),
        .rst_i  (reset),
        .pwm_i  (pwm_in),
        .rise_o (rise),
        .fall_o (fall)
    );

    pwm_state_e   state_q;
    logic [W-1:0] cnt_q;
    logic [W-1:0] high_lat_q;
    logic [W-1:0] duty_q;
    logic [W-1:0] final_q;
    logic         valid_q;
    logic         stuck_q;
    logic         at_limit;

    // >= rather than == so that a fall taken exactly at the limit (which lets
    // cnt step to MAX) still times out in LOW instead of running on.
    assign at_limit = (cnt_q >= Limit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            high_lat_q <= '0;
            duty_q     <= '0;
            final_q    <= '0;
            valid_q    <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            // Saturate so the counter can never wrap back into range.
            if (cnt_q != MaxVal) begin
                cnt_q <= cnt_q + W'(1);
            end

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    // First rise only starts a measurement; the period before
                    // it was not seen from its beginning.
                    if (rise) begin
                        state_q <= HIGH;
                    end
                end

                HIGH: begin
                    if (fall) begin
                        state_q    <= LOW;
                        high_lat_q <= cnt_q + W'(1);
                    end else if (at_limit) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        stuck_q <= 1'b1;
                        final_q <= MaxVal;
                        duty_q  <= MaxVal;
                    end
                end

                LOW: begin
                    if (rise) begin
                        state_q <= HIGH;
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        stuck_q <= 1'b0;
                        final_q <= cnt_q;
                        duty_q  <= high_lat_q;
                    end else if (at_limit) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        stuck_q <= 1'b1;
                        final_q <= MaxVal;
                        duty_q  <= '0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign duty        = duty_q;
    assign final_value = final_q;
    assign valid       = valid_q;
    assign stuck       = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture
// Self-checking bench for pwm_capture. The input is driven synchronously to
// the clock; a timestamp model predicts each report (edge, duty, final_value,
// stuck) from the driven input edges, and a monitor records what the DUT
// reports. A reduced width keeps the timeout tests short.
// -----------------------------------------------------------------------------
module tb_pwm_capture;

    localparam int unsigned TW  = 10;
    localparam int unsigned MAX = (1 << TW) - 1;

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int unsigned FILT = 4;
`else
    localparam int unsigned FILT = 0;
`endif
    // Input change after edge c is first visible as an output change at edge c+LAT.
    localparam int unsigned LAT    = 3 + FILT;
    localparam int unsigned MINSEG = (FILT > 0) ? FILT : 1;
    localparam int unsigned P0     = (FILT > 0) ? 14 : 10;
    localparam int unsigned H0     = (FILT > 0) ? 4 : 3;
    localparam int unsigned H1     = 7;
    localparam bit          GN     = (FILT == 0);

    typedef struct {
        int unsigned at;
        int unsigned duty;
        int unsigned fv;
        int unsigned stuck;
    } rep_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pwm_in = 1'b0;
    logic [TW-1:0] duty;
    logic [TW-1:0] final_value;
    logic          valid;
    logic          stuck;

    int unsigned cyc = 0;
    int unsigned total = 0;
    int unsigned bad = 0;

    rep_t exp_q[$];
    rep_t obs_q[$];

    // Model state: measuring, time of last rise, whether a fall followed it.
    bit          meas = 1'b0;
    bit          fall_seen = 1'b0;
    int unsigned r_edge = 0;
    int unsigned h_len = 0;

    pwm_capture #(
        .W        (TW),
        .FILT_LEN (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pwm_in      (pwm_in),
        .duty        (duty),
        .final_value (final_value),
        .valid       (valid),
        .stuck       (stuck)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            obs_q.push_back('{at: cyc, duty: int'(duty), fv: int'(final_value),
                              stuck: int'(stuck)});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input int unsigned expv);
        total++;
        assert (obs === 32'(expv))
        else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Emit the timeout report if it falls at or before edge 'limit'.
    task automatic model_timeout(input int unsigned limit);
        if (meas && (r_edge + MAX <= limit)) begin
            exp_q.push_back('{at: r_edge + MAX, duty: (fall_seen ? 0 : MAX), fv: MAX, stuck: 1});
            meas = 1'b0;
        end
    endtask

    task automatic model_event(input bit lvl, input int unsigned c);
        int unsigned d;
        d = c + LAT;
        model_timeout(d - 1);
        if (lvl) begin
            if (meas && fall_seen) begin
                exp_q.push_back('{at: d, duty: h_len, fv: d - r_edge - 1, stuck: 0});
            end
            meas      = 1'b1;
            r_edge    = d;
            fall_seen = 1'b0;
        end else if (meas && !fall_seen) begin
            h_len     = d - r_edge;
            fall_seen = 1'b1;
        end
    endtask

    // Hold 'lvl' for n cycles; 'notify' = 0 hides the change from the model.
    task automatic seg(input bit lvl, input int unsigned n, input bit notify);
        if (lvl != pwm_in && notify) model_event(lvl, cyc);
        pwm_in = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic period(input int unsigned p, input int unsigned h);
        seg(1'b1, h, 1'b1);
        seg(1'b0, p - h, 1'b1);
    endtask

    task automatic check_reports(input string tag);
        repeat (LAT + 2) begin
            @(posedge clk);
            #1;
        end
        model_timeout(cyc - 1);
        chk({tag, "/count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk($sformatf("%s/%0d/edge", tag, i), obs_q[i].at, exp_q[i].at);
            chk($sformatf("%s/%0d/duty", tag, i), obs_q[i].duty, exp_q[i].duty);
            chk($sformatf("%s/%0d/final", tag, i), obs_q[i].fv, exp_q[i].fv);
            chk($sformatf("%s/%0d/stuck", tag, i), obs_q[i].stuck, exp_q[i].stuck);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        int unsigned p;
        int unsigned h;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset/duty", duty, 0);
        chk("reset/final", final_value, 0);
        chk("reset/valid", valid, 0);
        chk("reset/stuck", stuck, 0);
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // Steady PWM
        repeat (6) period(P0, H0);
        check_reports("steady");

        // Duty change at a period boundary
        repeat (3) period(P0, H0);
        repeat (3) period(P0, H1);
        check_reports("duty_change");

`ifndef PWM_CAPTURE_FILTER_EN
        // Minimum period
        repeat (8) period(2, 1);
        check_reports("min_period");
`endif

        // Random periods
        for (int i = 0; i < 20; i++) begin
            p = $urandom_range(20, 2 * MINSEG);
            h = $urandom_range(p - MINSEG, MINSEG);
            period(p, h);
        end
        check_reports("random");

        // Short glitch inside the low phase
        repeat (3) period(P0, H0);
        seg(1'b1, H0, 1'b1);
        seg(1'b0, 4, 1'b1);
        seg(1'b1, 2, GN);
        seg(1'b0, P0 - H0 - 6, GN);
        repeat (3) period(P0, H0);
        check_reports("glitch");

        // Stuck low
        repeat (3) period(P0, H0);
        seg(1'b0, MAX + 20, 1'b1);
        check_reports("stuck_low");
        chk("stuck_low/hold_final", final_value, MAX);
        chk("stuck_low/hold_stuck", stuck, 1);

        // Stuck high
        repeat (3) period(P0, H0);
        seg(1'b1, MAX + 20, 1'b1);
        check_reports("stuck_high");
        chk("stuck_high/hold_duty", duty, MAX);

        // Reset in the middle of HIGH
        seg(1'b0, 10, 1'b1);
        repeat (3) period(P0, H0);
        seg(1'b1, LAT + 2, 1'b1);
        reset  = 1'b1;
        pwm_in = 1'b0;
        meas   = 1'b0;
        while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].at > cyc) void'(exp_q.pop_back());
        #1;
        chk("mid_reset/duty", duty, 0);
        chk("mid_reset/final", final_value, 0);
        chk("mid_reset/valid", valid, 0);
        chk("mid_reset/stuck", stuck, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        seg(1'b0, 5, 1'b1);
        repeat (4) period(P0, H0);
        check_reports("mid_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
